// File: rtl/nios_base_cpu_jtag_debug_sysclk_bridge.sv
// rtl/nios_base_cpu_jtag_debug_sysclk_bridge.sv - system-clock half of the CPU JTAG debug bridge
// Synchronises update strobes, latches IR, captures scan data and issues per-channel action pulses.
module nios_base_cpu_jtag_debug_sysclk_bridge #(
    parameter int IR_WIDTH    = 2,
    parameter int SR_WIDTH    = 38,
    parameter int ACT_BIT     = 35,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [IR_WIDTH-1:0]        ir_in,
    input  logic [SR_WIDTH-1:0]        sr,
    input  logic                       vs_uir,
    input  logic                       vs_udr,
    output logic [SR_WIDTH-1:0]        jdo,
    output logic [IR_WIDTH-1:0]        ir_latched,
    output logic                       cmd_valid,
    output logic [IR_WIDTH-1:0]        cmd_ch,
    output logic                       cmd_action,
    input  logic                       cmd_ready,
    output logic [(2**IR_WIDTH)-1:0]   take_action,
    output logic [(2**IR_WIDTH)-1:0]   take_no_action,
    output logic                       overrun,
    input  logic                       overrun_clr
);

    localparam int NUM_CH    = 2**IR_WIDTH;
    localparam int GUARD_MAX = SYNC_STAGES + 1;
    localparam int GW        = $clog2(GUARD_MAX + 1);

    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

    logic [SYNC_STAGES-1:0] uir_sync;
    logic [SYNC_STAGES-1:0] udr_sync;
    logic                   uir_prev;
    logic                   udr_prev;
    logic                   uir_rise;
    logic                   udr_rise;
    logic [GW-1:0]          guard_cnt;
    logic                   guard_done;
    state_t                 state;

    logic [IR_WIDTH-1:0]    cmd_ir;
    logic [NUM_CH-1:0]      ch_onehot;
    logic                   load;

    assign guard_done = (guard_cnt == GW'(GUARD_MAX));

    // Rises are registered, so the masked edge reaches the FSM one cycle after sync_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            uir_sync  <= '0;
            udr_sync  <= '0;
            uir_prev  <= 1'b0;
            udr_prev  <= 1'b0;
            uir_rise  <= 1'b0;
            udr_rise  <= 1'b0;
            guard_cnt <= '0;
        end else begin
            uir_sync  <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_sync  <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_prev  <= uir_sync[SYNC_STAGES-1];
            udr_prev  <= udr_sync[SYNC_STAGES-1];
            uir_rise  <= uir_sync[SYNC_STAGES-1] & ~uir_prev & guard_done;
            udr_rise  <= udr_sync[SYNC_STAGES-1] & ~udr_prev & guard_done;
            if (!guard_done) begin
                guard_cnt <= guard_cnt + GW'(1);
            end
        end
    end

    // A same-cycle IR update takes effect for the command being loaded.
    assign cmd_ir    = uir_rise ? ir_in : ir_latched;
    assign ch_onehot = NUM_CH'(1) << cmd_ir;
    assign load      = udr_rise && ((state == IDLE) || cmd_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            jdo            <= '0;
            ir_latched     <= '0;
            cmd_valid      <= 1'b0;
            cmd_ch         <= '0;
            cmd_action     <= 1'b0;
            take_action    <= '0;
            take_no_action <= '0;
            overrun        <= 1'b0;
        end else begin
            take_action    <= '0;
            take_no_action <= '0;
            if (uir_rise) begin
                ir_latched <= ir_in;
            end
            if (overrun_clr) begin
                overrun <= 1'b0;
            end
            if (load) begin
                state      <= PEND;
                cmd_valid  <= 1'b1;
                jdo        <= sr;
                cmd_ch     <= cmd_ir;
                cmd_action <= sr[ACT_BIT];
                if (sr[ACT_BIT]) begin
                    take_action <= ch_onehot;
                end else begin
                    take_no_action <= ch_onehot;
                end
            end else if ((state == PEND) && udr_rise) begin
                overrun <= 1'b1;
            end else if ((state == PEND) && cmd_ready) begin
                state     <= IDLE;
                cmd_valid <= 1'b0;
            end
        end
    end

endmodule
